// File: rtl/keypad_hex_encoder.sv
// Scans a 4x4 active-low keypad and emits one debounced hex code per press with a one-cycle strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while the accepted key stays held.
module keypad_hex_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_hex,
    output logic       key_valid,
    output logic       key_held
);
    // state    | meaning
    // SCAN     | walking rows, waiting for exactly one low column on a tick
    // DEBOUNCE | row frozen, counting ticks with the same single low column
    // HELD     | key accepted, waiting for its column to read high
    // RELEASE  | counting ticks with the column high before rescanning

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_hex_encoder: parameter out of range");
    end

    state_t        state_q;
    logic [3:0]    meta_q;
    logic [3:0]    csync_q;
    logic [SW-1:0] scan_cnt_q;
    logic [SW-1:0] scan_cnt_d;
    logic          tick;
    logic [1:0]    row_q;
    logic [1:0]    col_q;
    logic [DW-1:0] db_q;
    logic [3:0]    key_hex_q;
    logic          key_valid_q;
    logic          key_held_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_q;
`endif

    function automatic logic one_low(input logic [3:0] c);
        return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        if (!c[1]) idx = 2'd1;
        if (!c[2]) idx = 2'd2;
        if (!c[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] low_mask(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick       = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign scan_cnt_d = tick ? '0 : scan_cnt_q + SW'(1);

    // cols is asynchronous to clk; only csync_q feeds decisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= 4'hF;
            csync_q    <= 4'hF;
            scan_cnt_q <= '0;
        end else begin
            meta_q     <= cols;
            csync_q    <= meta_q;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            db_q        <= '0;
            key_hex_q   <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (one_low(csync_q)) begin
                            col_q   <= low_index(csync_q);
                            db_q    <= DW'(DEBOUNCE_TICKS);
                            state_q <= DEBOUNCE;
                        end else begin
                            row_q <= row_q + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (csync_q == low_mask(col_q)) begin
                            if (db_q == DW'(1)) begin
                                key_hex_q   <= key_map(row_q, col_q);
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state_q     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_q       <= RW'(REPEAT_DELAY);
`endif
                            end else begin
                                db_q <= db_q - DW'(1);
                            end
                        end else begin
                            state_q <= SCAN;
                            row_q   <= row_q + 2'd1;
                        end
                    end
                    HELD: begin
                        // Only the captured column matters; a second key is ignored.
                        if (csync_q[col_q]) begin
                            db_q    <= DW'(DEBOUNCE_TICKS);
                            state_q <= RELEASE;
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rep_q == RW'(1)) begin
                            key_valid_q <= 1'b1;
                            rep_q       <= RW'(REPEAT_PERIOD);
                        end else begin
                            rep_q <= rep_q - RW'(1);
                        end
`endif
                    end
                    RELEASE: begin
                        if (!csync_q[col_q]) begin
                            state_q <= HELD;
                        end else if (db_q == DW'(1)) begin
                            state_q    <= SCAN;
                            row_q      <= row_q + 2'd1;
                            key_held_q <= 1'b0;
                        end else begin
                            db_q <= db_q - DW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign rows      = ~(4'b0001 << row_q);
    assign key_hex   = key_hex_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_hex_encoder.sv
// Scoreboard bench for keypad_hex_encoder: a keypad model drives cols from rows and a pressed-key matrix.
module tb_keypad_hex_encoder;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_hex;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_seen = 0;

    typedef struct {
        logic [3:0] hex;
        int         at;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    keypad_hex_encoder #(
        .SCAN_DIV(SD), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows),
        .key_hex(key_hex), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its column to its row line.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] kb(input int r, input int c);
        logic [15:0] v;
        v = '0;
        v[r*4+c] = 1'b1;
        return v;
    endfunction

    // Capture tick for a key held from reset release: its row's dwell ends at r*SD+SD-1.
    function automatic int accept_cycle_from_reset(input int r);
        return r*SD + SD - 1 + DB*SD + 1;
    endfunction

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] keys);
        @(negedge clk);
        reset   = 1'b1;
        pressed = keys;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && key_valid) begin
            valid_seen++;
            if (sbq.size() == 0) begin
                chk("unexpected_strobe", int'(key_valid), 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("strobe_hex", int'(key_hex), int'(mon_e.hex));
                if (mon_e.at >= 0) chk("strobe_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int budget;
        int exp_n;

        @(negedge clk);
        chk("reset_rows", int'(rows), 4'hE);
        chk("reset_hex", int'(key_hex), 0);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_held", int'(key_held), 0);

        // r1c2 held from reset release
        do_reset(kb(1, 2));
        sbq.push_back('{4'h6, accept_cycle_from_reset(1)});
        at_cyc(21);
        chk("t2_held", int'(key_held), 1);
        chk("t2_rows_frozen", int'(rows), 4'hD);
        at_cyc(30);
        chk("t2_rows_frozen_late", int'(rows), 4'hD);
        chk("t2_hex", int'(key_hex), 4'h6);
        chk("t2_single_strobe", valid_seen, 1);
        at_cyc(32);
        pressed = '0;
        at_cyc(47);
        chk("t2_held_before_drop", int'(key_held), 1);
        at_cyc(48);
        chk("t2_held_drop", int'(key_held), 0);

        // reset asserted while r0c3 is being debounced
        pressed = kb(0, 3);
        at_cyc(62);
        reset = 1'b1;
        #1;
        chk("t1_rows", int'(rows), 4'hE);
        chk("t1_hex", int'(key_hex), 0);
        chk("t1_valid", int'(key_valid), 0);
        chk("t1_held", int'(key_held), 0);
        pressed = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        at_cyc(3);
        chk("t1_rows_row0", int'(rows), 4'hE);
        at_cyc(4);
        chk("t1_rows_row1", int'(rows), 4'hD);

        // hold r0c3, add r2c0, release r0c3
        do_reset(kb(0, 3));
        sbq.push_back('{4'hA, accept_cycle_from_reset(0)});
        at_cyc(20);
        pressed = pressed | kb(2, 0);
        at_cyc(24);
        pressed = pressed & ~kb(0, 3);
        at_cyc(39);
        chk("t4_held_before_drop", int'(key_held), 1);
        at_cyc(40);
        chk("t4_held_drop", int'(key_held), 0);
        chk("t4_rows_advanced", int'(rows), 4'hD);
        sbq.push_back('{4'h7, 47 + DB*SD + 1});
        at_cyc(61);
        chk("t4_hex_second", int'(key_hex), 4'h7);
        at_cyc(64);
        pressed = '0;
        at_cyc(80);
        chk("t4_second_release", int'(key_held), 0);

        // r3c1 low for two ticks only
        chk("t3_rows_row3", int'(rows), 4'h7);
        pressed = kb(3, 1);
        at_cyc(88);
        pressed = '0;
        at_cyc(91);
        chk("t3_rows_frozen", int'(rows), 4'h7);
        at_cyc(92);
        chk("t3_rows_wrap", int'(rows), 4'hE);
        at_cyc(100);
        chk("t3_hex_unchanged", int'(key_hex), 4'h7);

        // two columns low on row 2
        chk("t5_rows_row2", int'(rows), 4'hB);
        pressed = kb(2, 0) | kb(2, 2);
        at_cyc(103);
        chk("t5_cols_pattern", int'(cols), 4'hA);
        at_cyc(104);
        chk("t5_rows_row3", int'(rows), 4'h7);
        pressed = '0;
        at_cyc(108);
        chk("t5_rows_row0", int'(rows), 4'hE);

        // hold r2c1 twelve ticks past accept
        base = valid_seen;
        do_reset(kb(2, 1));
        sbq.push_back('{4'h8, accept_cycle_from_reset(2)});
`ifdef KEYPAD_REPEAT_EN
        for (int k = 0; k < 4; k++)
            sbq.push_back('{4'h8, accept_cycle_from_reset(2) + (RD + k*RP)*SD});
        exp_n = 5;
`else
        exp_n = 1;
`endif
        at_cyc(accept_cycle_from_reset(2) + 12*SD);
        pressed = '0;
        at_cyc(90);
        chk("t6_strobe_count", valid_seen - base, exp_n);
        chk("t6_released", int'(key_held), 0);

        // randomized presses
        do_reset('0);
        for (int it = 0; it < 20; it++) begin
            int r;
            int c;
            int c2;
            int kind;
            r    = $urandom_range(3);
            c    = $urandom_range(3);
            kind = $urandom_range(2);
            if (kind == 0) begin
                sbq.push_back('{kmap[r*4+c], -1});
                base    = valid_seen;
                pressed = kb(r, c);
                budget  = (6 + DB)*SD + 8;
                while (valid_seen == base && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                chk("rand_accept_seen", int'(valid_seen != base), 1);
                repeat ($urandom_range(0, (RD - 2)*SD)) @(negedge clk);
            end else if (kind == 1) begin
                pressed = kb(r, c);
                repeat ($urandom_range(1, DB*SD)) @(negedge clk);
            end else begin
                c2      = (c + 1 + $urandom_range(2)) % 4;
                pressed = kb(r, c) | kb(r, c2);
                repeat ((6 + DB)*SD) @(negedge clk);
            end
            pressed = '0;
            repeat ((DB + 3)*SD + 4) @(negedge clk);
            chk("rand_idle_held", int'(key_held), 0);
        end

        repeat (2*SD) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
